// File: rtl/rv_pkg.sv
// Shared RV64 constants used by the fetch stage and its neighbours (decode, imm gen).
package rv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [6:0] {
    OP_IMM = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011
  } opcode_e;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding {pc, instr} pairs between the imem response and decode.
module fetch_fifo import rv_pkg::*; #(
  parameter int unsigned WIDTH = XLEN + ILEN,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// RV64 instruction-fetch stage: PC, credit-limited imem requests, fetch FIFO, redirect flush.
// Optional feature macro: IFETCH_PERF_CNT_EN adds saturating perf_fetched / perf_flushed counters.
module instr_fetch import rv_pkg::*; #(
  parameter int unsigned     XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_flushed
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned W  = XLEN + ILEN;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [W-1:0]    head;
  logic [XLEN-1:0] redirect_addr;
  logic            pop;
  logic            push;
  logic            credit_ok;
  logic            issue;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};

  // A redirect cancels both the response arriving now and any decode handshake this cycle.
  assign id_valid  = (count != '0);
  assign pop       = id_valid && id_ready && !redirect_valid;
  assign push      = inflight && !redirect_valid;
  assign credit_ok = (32'(count) + 32'(inflight) + 32'd1) <= (32'(DEPTH) + 32'(pop));
  assign issue     = rst_n && (redirect_valid || credit_ok);

  assign imem_req  = issue;
  assign imem_addr = redirect_valid ? redirect_addr : pc;
  assign id_pc     = id_valid ? head[W-1:ILEN] : '0;
  assign id_instr  = id_valid ? head[ILEN-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= issue;
      inflight_pc <= imem_addr;
      if (issue) pc <= imem_addr + XLEN'(4);
    end
  end

  fetch_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({inflight_pc, imem_rdata}),
    .count (count),
    .head  (head)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [64:0] flushed_sum;

  always_comb flushed_sum = {1'b0, perf_flushed} + 65'(count) + 65'(inflight);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 64'd1;
      if (redirect_valid) perf_flushed <= flushed_sum[64] ? '1 : flushed_sum[63:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level model of the expected PC stream and credit rule.
module tb_instr_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_flushed;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  instr_fetch #(
    .XLEN     (64),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  // Reference model: the sequence of PCs decode must see, the fetch address stream,
  // and the number of fetches still owed to decode (bounded by DEPTH).
  logic [63:0] m_exp_pc;
  logic [63:0] m_fetch_pc;
  int          m_since;
  int          m_out;
  logic [63:0] m_fetched;
  logic [63:0] m_flushed;

  always @(negedge clk) begin
    logic        exp_valid;
    logic        exp_req;
    logic        m_pop;
    logic [63:0] tgt;
    if (!rst_n) begin
      check("reset id_valid", id_valid, 0);
      check("reset imem_req", imem_req, 0);
      check("reset id_pc", id_pc, 0);
      check("reset id_instr", id_instr, 0);
      m_exp_pc   = RST_PC;
      m_fetch_pc = RST_PC;
      m_since    = 0;
      m_out      = 0;
      m_fetched  = 0;
      m_flushed  = 0;
    end else begin
      tgt       = {redirect_pc[63:2], 2'b00};
      exp_valid = (m_since >= 2);
      m_pop     = exp_valid && id_ready && !redirect_valid;
      exp_req   = redirect_valid || (m_out - int'(m_pop) + 1 <= DEPTH);
      check("id_valid", id_valid, exp_valid);
      if (exp_valid) begin
        check("id_pc", id_pc, m_exp_pc);
        check("id_instr", id_instr, mem_word(m_exp_pc));
      end
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, redirect_valid ? tgt : m_fetch_pc);
`ifdef IFETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_flushed", perf_flushed, m_flushed);
`endif
      if (redirect_valid) begin
        m_flushed  = m_flushed + 64'(m_out);
        m_out      = 1;
        m_exp_pc   = tgt;
        m_fetch_pc = tgt + 64'd4;
        m_since    = 1;
      end else begin
        if (m_pop) begin
          m_exp_pc  = m_exp_pc + 64'd4;
          m_fetched = m_fetched + 64'd1;
        end
        m_out = m_out - int'(m_pop) + int'(exp_req);
        if (exp_req) m_fetch_pc = m_fetch_pc + 64'd4;
        if (m_since < 2) m_since++;
      end
    end
  end

  task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc);
    @(posedge clk);
    #1;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  logic [63:0] held_pc;
  logic [63:0] rnd_pc;

  initial begin
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    id_ready = 1'b1;
    #1;
    check("c0 imem_req", imem_req, 1);
    check("c0 imem_addr", imem_addr, 64'h0);
    step(1, 0, 0);
    check("c1 id_valid", id_valid, 0);
    step(1, 0, 0);
    check("c2 id_valid", id_valid, 1);
    check("c2 id_pc", id_pc, 64'h0);
    check("c2 id_instr", id_instr, 32'h0);
    step(1, 0, 0);
    check("c3 id_pc", id_pc, 64'h4);
    check("c3 id_instr", id_instr, 32'h1);
    repeat (6) step(1, 0, 0);

    step(0, 0, 0);
    held_pc = id_pc;
    repeat (4) step(0, 0, 0);
    check("stall imem_req", imem_req, 0);
    check("stall id_pc", id_pc, held_pc);
    repeat (5) step(1, 0, 0);

    repeat (3) step(0, 0, 0);
    step(0, 1, 64'h100);
    check("redir imem_addr", imem_addr, 64'h100);
    step(1, 0, 0);
    check("redir bubble", id_valid, 0);
    step(1, 0, 0);
    check("redir first pc", id_pc, 64'h100);
    step(1, 0, 0);
    check("redir second pc", id_pc, 64'h104);

    step(1, 1, 64'h203);
    check("align imem_addr", imem_addr, 64'h200);
    step(1, 1, 64'h40);
    step(1, 1, 64'h80);
    step(1, 0, 0);
    step(1, 0, 0);
    check("b2b valid", id_valid, 1);
    check("b2b first pc", id_pc, 64'h80);

    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0);
    step(1, 0, 0);
    check("wrap last pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0);
    check("wrap next pc", id_pc, 64'h0);

    for (int i = 0; i < 3000; i++) begin
      rnd_pc = {$urandom, $urandom};
      if ($urandom_range(3) == 0) rnd_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'(rnd_pc[4:0]);
      step($urandom_range(99) < 70, $urandom_range(99) < 5, rnd_pc);
    end

    step(1, 0, 0);
    step(1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst id_valid", id_valid, 0);
    check("midrst imem_req", imem_req, 0);
`ifdef IFETCH_PERF_CNT_EN
    check("midrst perf_fetched", perf_fetched, 0);
    check("midrst perf_flushed", perf_flushed, 0);
`endif
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    #1;
    check("restart imem_addr", imem_addr, RST_PC);
    repeat (2) step(1, 0, 0);
    check("restart id_pc", id_pc, RST_PC);
    repeat (5) step(1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
